afifo_rd_ptr: RTL



---
 rtl/afifo_rd_ptr_pkg.sv | 9 +
 rtl/gry2bin.sv | 14 +
 rtl/afifo_rd_ptr.sv | 73 +++++++
 3 files changed

// File: rtl/afifo_rd_ptr_pkg.sv
// Shared constants for the async FIFO pointer controllers.
// Pointers carry one extra wrap bit above the address width.
package afifo_rd_ptr_pkg;
  localparam int AFIFO_PTR_W_DEF = 4;

  function automatic int afifo_ptr_bits(input int ptr_w);
    return ptr_w + 1;
  endfunction
endpackage

// File: rtl/gry2bin.sv
// Combinational gray-to-binary decode; shared by the read and write controllers.
// Each binary bit is the XOR of all gray bits at or above it.
module gry2bin
  import afifo_rd_ptr_pkg::*;
#(
  parameter int WIDTH = afifo_ptr_bits(AFIFO_PTR_W_DEF)
) (
  input  logic [WIDTH-1:0] gry,
  output logic [WIDTH-1:0] bin
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^(gry >> i);
  end
endmodule

// File: rtl/afifo_rd_ptr.sv
// Read-side pointer controller of the async FIFO: syncs the gray write pointer,
// tracks the read pointer and derives empty, fill count, underflow and pointer errors.
module afifo_rd_ptr
  import afifo_rd_ptr_pkg::*;
#(
  parameter int PTR_W       = AFIFO_PTR_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [afifo_ptr_bits(PTR_W)-1:0]     wr_gry_ptr,
  input  logic                                 rd_en,
  input  logic                                 udf_clr,
  output logic [PTR_W-1:0]                     rd_addr,
  output logic [afifo_ptr_bits(PTR_W)-1:0]     rd_gry_ptr,
  output logic                                 empty,
  output logic [afifo_ptr_bits(PTR_W)-1:0]     fill_cnt,
  output logic                                 udf,
  output logic                                 ptr_err
);
  localparam int PB = afifo_ptr_bits(PTR_W);
  localparam logic [PB-1:0] DEPTH = {1'b1, {PTR_W{1'b0}}};

  logic [SYNC_STAGES-1:0][PB-1:0] sync_q;
  logic [PB-1:0] wr_gry_s, wr_gry_prev_f, wr_bin_c, wr_bin_f;
  logic [PB-1:0] rd_bin_f, rd_bin_nxt_c, gry_diff_c, occ_c;
  logic          pop_c, gry_bad_c, overrun_c;

  // Plain flop chain: no logic between stages so each bit resolves independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], wr_gry_ptr};
  end
  assign wr_gry_s = sync_q[SYNC_STAGES-1];

  gry2bin #(.WIDTH(PB)) u_wr_dec (
    .gry (wr_gry_s),
    .bin (wr_bin_c)
  );

  assign pop_c        = rd_en & ~empty;
  assign rd_bin_nxt_c = rd_bin_f + PB'(pop_c);
  assign rd_addr      = rd_bin_f[PTR_W-1:0];

  // More than one set bit in the step means the write pointer skipped a gray code.
  assign gry_diff_c = wr_gry_s ^ wr_gry_prev_f;
  assign gry_bad_c  = |(gry_diff_c & (gry_diff_c - 1'b1));
  assign occ_c      = wr_bin_f - rd_bin_f;
  assign overrun_c  = occ_c > DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_f      <= '0;
      wr_gry_prev_f <= '0;
      rd_bin_f      <= '0;
      rd_gry_ptr    <= '0;
      empty         <= 1'b1;
      fill_cnt      <= '0;
      udf           <= 1'b0;
      ptr_err       <= 1'b0;
    end else begin
      wr_bin_f      <= wr_bin_c;
      wr_gry_prev_f <= wr_gry_s;
      rd_bin_f      <= rd_bin_nxt_c;
      rd_gry_ptr    <= rd_bin_nxt_c ^ (rd_bin_nxt_c >> 1);
      empty         <= (rd_bin_nxt_c == wr_bin_f);
      fill_cnt      <= wr_bin_f - rd_bin_nxt_c;
      if (rd_en && empty) udf <= 1'b1;
      else if (udf_clr)   udf <= 1'b0;
      if (gry_bad_c || overrun_c) ptr_err <= 1'b1;
    end
  end
endmodule
